// File: rtl/blood_pkg.sv
// Shared blood-type codes, scheduler state encoding and code validity check.
// Pure definitions: no latency, no flow control.
package blood_pkg;

    localparam logic [2:0] BT_O = 3'b001;
    localparam logic [2:0] BT_A = 3'b010;
    localparam logic [2:0] BT_B = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    function automatic logic is_onehot_code(input logic [2:0] code);
        return (code == BT_O) || (code == BT_A) || (code == BT_B);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching from the ward after the last accepted one.
// The pointer advances only when the grant is accepted; an unaccepted grant leaves priority unchanged.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!grant_vld && req[j]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(j);
                grant[j]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && grant_vld) begin
            ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/blood_request_scheduler.sv
// Time-shares one blood-type classifier among N_REQ wards; done 3 cycles after grant (2 for an invalid code).
// Wards hold req until done; requests are sampled only in IDLE, so there is no back-to-back grant.
module blood_request_scheduler
    import blood_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] req_type,
    output logic [N_REQ-1:0]   done,
    output logic               result_class,
    output logic               result_err,
    output logic [2:0]         cls_blood_type,
    input  logic               cls_blood_class,
    output logic               busy,
    output logic [CNT_W-1:0]   served_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic [2:0]       sel_type;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]       type_q;
    logic             class_q;
    logic             code_ok;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .accept    (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        sel_type = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) sel_type = req_type[3*i +: 3];
        end
    end

    assign code_ok = is_onehot_code(type_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx_q      <= '0;
            type_q     <= '0;
            class_q    <= 1'b0;
            served_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant_vld) begin
                idx_q  <= grant_idx;
                type_q <= sel_type;
            end
            if (state == CAPTURE) class_q <= cls_blood_class;
            if (state == RESPOND) served_cnt <= served_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        done           = '0;
        result_class   = 1'b0;
        result_err     = 1'b0;
        cls_blood_type = 3'b000;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                // An invalid code never reaches the classifier and skips the capture cycle.
                if (code_ok) begin
                    cls_blood_type = type_q;
                    state_nxt      = CAPTURE;
                end else begin
                    state_nxt = RESPOND;
                end
            end
            CAPTURE: begin
                cls_blood_type = type_q;
                state_nxt      = RESPOND;
            end
            RESPOND: begin
                done[idx_q]  = 1'b1;
                result_class = code_ok & class_q;
                result_err   = ~code_ok;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/blood_request_scheduler.md
BLOOD_REQUEST_SCHEDULER -- requirements
Module: blood_request_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of ward requesters sharing one blood-type classifier.
REQ-002 SHALL have parameter CNT_W, default 8: width of the served-request counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N_REQ: per-ward request level, held high until that ward's done pulse.
REQ-006 SHALL have port req_type, input, 3*N_REQ: per-ward 3-bit blood-type code; ward i uses bits [3i+2:3i].
REQ-007 SHALL have port done, output, N_REQ: one-cycle completion pulse to the served ward.
REQ-008 SHALL have port result_class, output, 1: classifier result for the completed request; valid only while done is nonzero.
REQ-009 SHALL have port result_err, output, 1: invalid-code flag; valid only while done is nonzero.
REQ-010 SHALL have port cls_blood_type, output, 3: drives the shared classifier's bloodType input.
REQ-011 SHALL have port cls_blood_class, input, 1: the shared classifier's combinational bloodClass output.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port served_cnt, output, CNT_W: count of completed requests, including errored ones.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, CAPTURE and RESPOND.
REQ-015 SHALL, in IDLE with any req bit high, grant one ward round-robin, searching from the ward after the last granted ward, latch its index and type, and go to ISSUE.
REQ-016 SHALL remain in IDLE while req is all zero.
REQ-017 SHALL, in ISSUE, drive cls_blood_type with the latched type and go to CAPTURE.
REQ-018 SHALL, in CAPTURE, hold cls_blood_type, register cls_blood_class and go to RESPOND.
REQ-019 SHALL, in RESPOND, assert done[idx] with the registered result_class, result_err=0, increment served_cnt and return to IDLE.
REQ-020 SHALL treat only one-hot latched codes (001, 010, 100) as valid.
REQ-021 SHALL send an invalid latched code directly from ISSUE to RESPOND with result_class=0, result_err=1 and the classifier not driven.
REQ-022 SHALL drive cls_blood_type to 000 in every cycle other than ISSUE and CAPTURE with a valid code.
REQ-023 SHALL give a valid request latency of exactly 3 cycles from the IDLE grant edge to the done pulse, and 2 cycles for an invalid one.
REQ-024 SHALL keep done at most one-hot, and all-zero outside RESPOND.
REQ-025 SHALL ignore req changes after the grant and until return to IDLE.
REQ-026 SHALL treat a req bit still high in the cycle after done as a new request.
REQ-027 SHALL let served_cnt wrap from all-ones to 0.
REQ-028 SHALL sample new requests only in IDLE, with no back-to-back grant without passing through IDLE.

Reset
REQ-029 SHALL, with rst_n low, force state=IDLE, done=0, result_class=0, result_err=0, cls_blood_type=000, busy=0, served_cnt=0 and round-robin pointer = ward 0 highest priority.
REQ-030 SHALL, on reset assertion mid-transaction, abort the transaction immediately with no done pulse; the aborted ward must re-request.

Structure
REQ-031 SHALL place the blood-type code constants (O=001, A=010, B=100), the state encoding and a one-hot check function in the shared package blood_pkg.
REQ-032 SHALL implement arbitration in the sub-module rr_arbiter (request vector, pointer update on grant accept, one-hot grant out), parameterised by N_REQ.
REQ-033 SHALL not contain the classifier; the classifier is instantiated beside this block at the top level.

Verification
REQ-034 SHALL cover: reset, then req=0001 with type 001 -> cls_blood_type=001 for 2 cycles, done=0001 exactly 3 cycles after grant, result_class equal to classifier output, served_cnt=1.
REQ-035 SHALL cover: req=1111 held, all types valid -> grant order ward 0,1,2,3,0 and one done per 4 cycles (grant, issue, capture, respond).
REQ-036 SHALL cover: ward 2 type 011 -> done=0100 two cycles after grant with result_err=1, result_class=0, and cls_blood_type staying 000.
REQ-037 SHALL cover: rst_n pulsed low during CAPTURE -> done never pulses, busy=0 immediately, next grant goes to ward 0.
REQ-038 SHALL cover: served_cnt preloaded by 255 completions, then one more -> served_cnt=0.
REQ-039 SHALL cover: ward 1 req dropped during ISSUE -> transaction still completes with done=0010.
